// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the LEGv8 memory-access stage:
//   - `WORD        : datapath width (64), shared with the rest of the datapath
//   - state_t      : FSM state type and its encodings (IDLE, WAIT_ACK, DRAIN)
//   - FAULT_*      : fault_code values reported to write-back
//   - CNT_W        : width of the transaction timeout counter (TIMEOUT <= 255)
//   - is_dword_aligned() : LDUR/STUR move 8-byte doublewords, so the low
//                          three address bits must be zero
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD 64
`endif

package mem_access_stage_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_WAIT_ACK = 2'd1;
    localparam state_t ST_DRAIN    = 2'd2;

    // fault_code values
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    // Timeout counter width; covers the full 2..255 TIMEOUT range
    localparam int CNT_W = 8;

    // Doubleword accesses must sit on an 8-byte boundary
    function automatic logic is_dword_aligned(input logic [`WORD-1:0] addr);
        return (addr[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/mem_access_stage_timeout.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles spent waiting on data memory. terminal is high on the
// TIMEOUT-th enabled cycle after a clear (count value TIMEOUT-1), and only
// while enable is high, so it can be used directly as the abort condition.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to zero (has priority over enable)
//   enable     : count this cycle
//   terminal   : TIMEOUT-th enabled cycle reached
// -----------------------------------------------------------------------------
module mem_timeout_counter
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter; saturates at LAST so it can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign terminal = enable & (r_count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access stage of the pipelined LEGv8 datapath. Non-memory ops are
// registered straight through to write-back. Aligned LDUR/STUR run one
// req/ack transaction with data memory while stalling the upstream stage;
// misaligned accesses and transactions that exceed TIMEOUT cycles are
// reported as faults with the register write suppressed. A flush during a
// transaction lets it drain silently (DRAIN) without stalling upstream.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_*                  : EX-stage bundle (valid, ALU result/address,
//                           store data, control bits, destination register)
//   flush                 : kill the in-flight instruction
//   stall                 : combinational hold request to upstream
//   dmem_req/we/addr/wdata: registered memory request, held until ack
//   dmem_rdata, dmem_ack  : memory response
//   wb_*                  : registered write-back bundle, wb_valid pulses
//   fault, fault_code     : fault pulse coincident with wb_valid
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [`WORD-1:0]  in_alu_result,
    input  logic [`WORD-1:0]  in_write_data,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [4:0]        in_write_reg,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [`WORD-1:0]  dmem_addr,
    output logic [`WORD-1:0]  dmem_wdata,
    input  logic [`WORD-1:0]  dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [`WORD-1:0]  wb_alu_result,
    output logic [`WORD-1:0]  wb_read_data,
    output logic [4:0]        wb_write_reg,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              fault,
    output logic [1:0]        fault_code
);

    state_t      r_state;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic [4:0]  r_write_reg;

    logic        w_mem_op;
    logic        w_aligned;
    logic        w_capture;
    logic        w_start;
    logic        w_timeout;
    logic        w_stall;

    assign w_mem_op  = in_mem_read | in_mem_write;
    assign w_aligned = is_dword_aligned(in_alu_result);
    // A flushed instruction is never captured, so it must not stall either
    assign w_capture = (r_state == ST_IDLE) & in_valid & ~flush;
    assign w_start   = w_capture & w_mem_op & w_aligned;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (r_state == ST_IDLE),
        .enable   (r_state != ST_IDLE),
        .terminal (w_timeout)
    );

    // Upstream hold request; ack or timeout releases it in the completing cycle
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE:     w_stall = w_start;
            ST_WAIT_ACK: w_stall = ~dmem_ack & ~w_timeout & ~flush;
            ST_DRAIN:    w_stall = in_valid & w_mem_op;
            default:     w_stall = 1'b0;
        endcase
    end

    // stall is the only combinational output, so it is forced low in reset
    assign stall = rst_n & w_stall;

    // FSM, memory request registers and write-back bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_write_reg   <= 5'd0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= {`WORD{1'b0}};
            dmem_wdata    <= {`WORD{1'b0}};
            wb_valid      <= 1'b0;
            wb_alu_result <= {`WORD{1'b0}};
            wb_read_data  <= {`WORD{1'b0}};
            wb_write_reg  <= 5'd0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= FAULT_NONE;
        end else begin
            // wb_valid and fault are single-cycle pulses
            wb_valid   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_capture && !w_start) begin
                        // Register-only op, or a misaligned access that
                        // never reaches memory
                        wb_valid      <= 1'b1;
                        wb_alu_result <= in_alu_result;
                        wb_read_data  <= {`WORD{1'b0}};
                        wb_write_reg  <= in_write_reg;
                        wb_mem_to_reg <= in_mem_to_reg;
                        if (w_mem_op) begin
                            wb_reg_write <= 1'b0;
                            fault        <= 1'b1;
                            fault_code   <= FAULT_MISALIGN;
                        end else begin
                            wb_reg_write <= in_reg_write;
                        end
                    end else if (w_start) begin
                        // Read+write together resolves to a write
                        dmem_req     <= 1'b1;
                        dmem_we      <= in_mem_write;
                        dmem_addr    <= in_alu_result;
                        dmem_wdata   <= in_write_data;
                        r_reg_write  <= in_reg_write;
                        r_mem_to_reg <= in_mem_to_reg;
                        r_write_reg  <= in_write_reg;
                        r_state      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (flush) begin
                        // Killed transaction: finish it silently
                        if (dmem_ack || w_timeout) begin
                            dmem_req <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state  <= ST_DRAIN;
                        end
                    end else if (dmem_ack) begin
                        // Ack wins over a timeout in the same cycle
                        dmem_req      <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_alu_result <= dmem_addr;
                        wb_read_data  <= dmem_we ? {`WORD{1'b0}} : dmem_rdata;
                        wb_write_reg  <= r_write_reg;
                        wb_reg_write  <= r_reg_write;
                        wb_mem_to_reg <= r_mem_to_reg;
                        r_state       <= ST_IDLE;
                    end else if (w_timeout) begin
                        dmem_req      <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_alu_result <= dmem_addr;
                        wb_read_data  <= {`WORD{1'b0}};
                        wb_write_reg  <= r_write_reg;
                        wb_reg_write  <= 1'b0;
                        wb_mem_to_reg <= r_mem_to_reg;
                        fault         <= 1'b1;
                        fault_code    <= FAULT_TIMEOUT;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_ack || w_timeout) begin
                        dmem_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage with TIMEOUT = 4. Each scenario task
// starts one time unit after a rising edge ("cycle 0"), drives inputs, waits
// one more unit and compares outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_alu_result;
    logic [63:0] in_write_data;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [4:0]  in_write_reg;
    logic        flush;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_read_data;
    logic [4:0]  wb_write_reg;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic        fault;
    logic [1:0]  fault_code;

    int checks;
    int failures;

    mem_access_stage #(
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_alu_result (in_alu_result),
        .in_write_data (in_write_data),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_write_reg  (in_write_reg),
        .flush         (flush),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .wb_valid      (wb_valid),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] wd,
                         input logic rd, input logic wr, input logic rw,
                         input logic m2r, input logic [4:0] r);
        in_valid      = v;
        in_alu_result = a;
        in_write_data = wd;
        in_mem_read   = rd;
        in_mem_write  = wr;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_write_reg  = r;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        flush      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        drive(1'b1, 64'h100, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
        checks++; if (dmem_addr !== 64'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", dmem_addr); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL reset_fault_code got=%b exp=00", fault_code); end
        next_cycle();
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req_held got=%0b exp=0", dmem_req); end
        idle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu_pass();
        drive(1'b1, 64'd25, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall); end
        next_cycle();
        idle();
        #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%0b exp=1", wb_valid); end
        checks++; if (wb_alu_result !== 64'd25) begin failures++; $display("FAIL alu_result got=%0d exp=25", wb_alu_result); end
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL alu_reg_write got=%0b exp=1", wb_reg_write); end
        checks++; if (wb_write_reg !== 5'd3) begin failures++; $display("FAIL alu_write_reg got=%0d exp=3", wb_write_reg); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL alu_fault got=%0b exp=0", fault); end
        next_cycle();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_wb_pulse got=%0b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) next_cycle();
            if (c <= 2) drive(1'b1, 64'(10 + c), 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(c + 1));
            else idle();
            #1;
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall c=%0d got=%0b exp=0", c, stall); end
            if (c >= 1) begin
                checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_wb_valid c=%0d got=%0b exp=1", c, wb_valid); end
                checks++; if (wb_alu_result !== 64'(9 + c)) begin failures++; $display("FAIL b2b_result c=%0d got=%0d exp=%0d", c, wb_alu_result, 9 + c); end
            end
        end
        next_cycle();
    endtask

    // Ack three cycles after req; with TIMEOUT=4 this ack lands on the
    // timeout threshold cycle, so it also shows ack beating the timeout.
    task automatic test_load();
        int stall_cnt;
        int wb_cnt;
        stall_cnt = 0;
        wb_cnt    = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle();
            if (c <= 4) drive(1'b1, 64'h100, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
            else idle();
            dmem_ack   = (c == 4);
            dmem_rdata = (c == 4) ? 64'hDEAD : 64'd0;
            #1;
            if (c <= 4) begin
                if (stall === 1'b1) stall_cnt++;
                if (wb_valid === 1'b1) wb_cnt++;
            end
            if (c == 1) begin
                checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL load_req got=%0b exp=1", dmem_req); end
                checks++; if (dmem_addr !== 64'h100) begin failures++; $display("FAIL load_addr got=%h exp=100", dmem_addr); end
                checks++; if (dmem_we !== 1'b0) begin failures++; $display("FAIL load_we got=%0b exp=0", dmem_we); end
            end
            if (c == 5) begin
                checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL load_wb_valid got=%0b exp=1", wb_valid); end
                checks++; if (wb_read_data !== 64'hDEAD) begin failures++; $display("FAIL load_rdata got=%h exp=dead", wb_read_data); end
                checks++; if (wb_alu_result !== 64'h100) begin failures++; $display("FAIL load_alu got=%h exp=100", wb_alu_result); end
                checks++; if (wb_write_reg !== 5'd7) begin failures++; $display("FAIL load_write_reg got=%0d exp=7", wb_write_reg); end
                checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL load_reg_write got=%0b exp=1", wb_reg_write); end
                checks++; if (wb_mem_to_reg !== 1'b1) begin failures++; $display("FAIL load_mem_to_reg got=%0b exp=1", wb_mem_to_reg); end
                checks++; if (fault !== 1'b0) begin failures++; $display("FAIL load_fault got=%0b exp=0", fault); end
                checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL load_req_drop got=%0b exp=0", dmem_req); end
            end
        end
        checks++; if (stall_cnt != 4) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=4", stall_cnt); end
        checks++; if (wb_cnt != 0) begin failures++; $display("FAIL load_early_wb got=%0d exp=0", wb_cnt); end
        next_cycle();
    endtask

    task automatic test_store();
        for (int c = 0; c <= 2; c++) begin
            if (c > 0) next_cycle();
            if (c <= 1) drive(1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
            else idle();
            dmem_ack = (c == 1);
            #1;
            if (c == 0) begin
                checks++; if (stall !== 1'b1) begin failures++; $display("FAIL store_stall0 got=%0b exp=1", stall); end
            end
            if (c == 1) begin
                checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL store_req got=%0b exp=1", dmem_req); end
                checks++; if (dmem_we !== 1'b1) begin failures++; $display("FAIL store_we got=%0b exp=1", dmem_we); end
                checks++; if (dmem_wdata !== 64'hFFFF_FFFF_FFFF_FFFB) begin failures++; $display("FAIL store_wdata got=%h exp=fffffffffffffffb", dmem_wdata); end
                checks++; if (dmem_addr !== 64'h08) begin failures++; $display("FAIL store_addr got=%h exp=8", dmem_addr); end
                checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_stall_ack got=%0b exp=0", stall); end
            end
            if (c == 2) begin
                checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL store_wb_valid got=%0b exp=1", wb_valid); end
                checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL store_reg_write got=%0b exp=0", wb_reg_write); end
                checks++; if (fault !== 1'b0) begin failures++; $display("FAIL store_fault got=%0b exp=0", fault); end
                checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL store_req_drop got=%0b exp=0", dmem_req); end
            end
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 64'h104, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%0b exp=0", stall); end
        next_cycle();
        idle();
        #1;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%0b exp=0", dmem_req); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL mis_wb_valid got=%0b exp=1", wb_valid); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%0b exp=1", fault); end
        checks++; if (fault_code !== 2'b01) begin failures++; $display("FAIL mis_code got=%b exp=01", fault_code); end
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL mis_reg_write got=%0b exp=0", wb_reg_write); end
        next_cycle();
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mis_fault_pulse got=%0b exp=0", fault); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL mis_req_later got=%0b exp=0", dmem_req); end
    endtask

    task automatic test_timeout();
        int req_cnt;
        int stall_cnt;
        req_cnt   = 0;
        stall_cnt = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) next_cycle();
            if (c <= 4) drive(1'b1, 64'h200, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
            else idle();
            #1;
            if (dmem_req === 1'b1) req_cnt++;
            if (stall === 1'b1) stall_cnt++;
            if (c == 5) begin
                checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL to_wb_valid got=%0b exp=1", wb_valid); end
                checks++; if (fault !== 1'b1) begin failures++; $display("FAIL to_fault got=%0b exp=1", fault); end
                checks++; if (fault_code !== 2'b10) begin failures++; $display("FAIL to_code got=%b exp=10", fault_code); end
                checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL to_reg_write got=%0b exp=0", wb_reg_write); end
            end
            if (c == 6) begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL to_wb_pulse got=%0b exp=0", wb_valid); end
            end
        end
        checks++; if (req_cnt != 4) begin failures++; $display("FAIL to_req_cycles got=%0d exp=4", req_cnt); end
        checks++; if (stall_cnt != 4) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=4", stall_cnt); end
        next_cycle();
    endtask

    // Flush in WAIT_ACK, then a second load held upstream while DRAIN finishes
    task automatic test_flush();
        int wb_cnt;
        int fault_cnt;
        wb_cnt    = 0;
        fault_cnt = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) next_cycle();
            idle();
            if (c <= 2) drive(1'b1, 64'h300, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
            else if (c <= 5) drive(1'b1, 64'h500, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
            flush      = (c == 2);
            dmem_ack   = (c == 3) || (c == 5);
            dmem_rdata = (c == 3) ? 64'h1111 : ((c == 5) ? 64'h2222 : 64'd0);
            #1;
            if (c <= 5) begin
                if (wb_valid === 1'b1) wb_cnt++;
                if (fault === 1'b1) fault_cnt++;
            end
            if (c == 2) begin
                checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall); end
            end
            if (c == 3) begin
                checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL drain_req got=%0b exp=1", dmem_req); end
                checks++; if (stall !== 1'b1) begin failures++; $display("FAIL drain_stall got=%0b exp=1", stall); end
            end
            if (c == 4) begin
                checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL drain_req_drop got=%0b exp=0", dmem_req); end
            end
            if (c == 5) begin
                checks++; if (dmem_addr !== 64'h500) begin failures++; $display("FAIL flush_next_addr got=%h exp=500", dmem_addr); end
            end
            if (c == 6) begin
                checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL flush_next_wb got=%0b exp=1", wb_valid); end
                checks++; if (wb_read_data !== 64'h2222) begin failures++; $display("FAIL flush_next_rdata got=%h exp=2222", wb_read_data); end
                checks++; if (wb_write_reg !== 5'd9) begin failures++; $display("FAIL flush_next_reg got=%0d exp=9", wb_write_reg); end
            end
        end
        checks++; if (wb_cnt != 0) begin failures++; $display("FAIL drain_wb_count got=%0d exp=0", wb_cnt); end
        checks++; if (fault_cnt != 0) begin failures++; $display("FAIL drain_fault_count got=%0d exp=0", fault_cnt); end
        idle();
        next_cycle();
    endtask

    task automatic test_flush_idle();
        drive(1'b1, 64'h33, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
        flush = 1'b1;
        next_cycle();
        idle();
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_wb got=%0b exp=0", wb_valid); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle();
            if (c <= 2) drive(1'b1, 64'h400, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
            else if (c == 4) drive(1'b1, 64'd9, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
            else idle();
            rst_n = (c == 2) ? 1'b0 : 1'b1;
            #1;
            if (c == 1) begin
                checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%0b exp=1", dmem_req); end
            end
            if (c == 2) begin
                checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%0b exp=0", dmem_req); end
                checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%0b exp=0", stall); end
                checks++; if (dmem_addr !== 64'd0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", dmem_addr); end
            end
            if (c == 5) begin
                checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL rstmid_idle_wb got=%0b exp=1", wb_valid); end
                checks++; if (wb_alu_result !== 64'd9) begin failures++; $display("FAIL rstmid_idle_alu got=%0d exp=9", wb_alu_result); end
                checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req_after got=%0b exp=0", dmem_req); end
            end
        end
        next_cycle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        test_reset();
        test_alu_pass();
        test_back_to_back();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined ARM (LEGv8) datapath. It sits directly downstream of the execute-stage ALU. It consumes the ALU result as a data address for LDUR/STUR, or passes it through for register-only ops. It runs a req/ack transaction with data memory, stalls the upstream pipeline while a transaction is outstanding, and delivers a registered result bundle to write-back.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles to wait for `dmem_ack` before aborting; legal range 2–255.
- Data width is `` `WORD `` (64) from the shared defines. It is not a parameter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX-side instruction present
- in_alu_result  in  `WORD  ALU result; the address for memory ops
- in_write_data  in  `WORD  store data (STUR)
- in_mem_read  in  1  LDUR
- in_mem_write  in  1  STUR
- in_reg_write  in  1  instruction writes a register
- in_mem_to_reg  in  1  write-back selects load data
- in_write_reg  in  5  destination register
- flush  in  1  kill the in-flight instruction
- stall  out  1  upstream must hold its outputs this cycle
- dmem_req  out  1  memory request; held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  `WORD  byte address
- dmem_wdata  out  `WORD  store data
- dmem_rdata  in  `WORD  load data; valid when ack = 1
- dmem_ack  in  1  single-cycle completion
- wb_valid  out  1  write-back bundle valid (1-cycle pulse per instruction)
- wb_alu_result  out  `WORD  registered ALU result
- wb_read_data  out  `WORD  registered load data
- wb_write_reg  out  5  destination register
- wb_reg_write  out  1  gated register-write enable
- wb_mem_to_reg  out  1  pass-through
- fault  out  1  1-cycle pulse with wb_valid on a misaligned access or timeout
- fault_code  out  2  00 none, 01 misaligned, 10 timeout

## Operation
- **FSM states:** IDLE, WAIT_ACK, DRAIN.
- **IDLE, in_valid = 1, no memory op:**
  - Capture the bundle.
  - Next cycle: wb_valid = 1 and wb_reg_write = in_reg_write.
  - Stay in IDLE.
- **IDLE, memory op, address[2:0] ≠ 0:**
  - No memory request is issued.
  - Next cycle: wb_valid = 1, fault = 1, fault_code = 01, wb_reg_write = 0.
- **IDLE, memory op, aligned:**
  - Latch address, data, we, and control.
  - stall = 1 combinationally this cycle.
  - Go to WAIT_ACK.
  - in_mem_read and in_mem_write both set: treat as a write. The bench flags this as illegal.
- **WAIT_ACK:**
  - dmem_req = 1, with address/we/wdata held stable.
  - A timeout counter increments each cycle.
  - On dmem_ack:
    - capture dmem_rdata (reads);
    - next cycle wb_valid = 1;
    - return to IDLE.
  - Counter reaches TIMEOUT without ack:
    - drop req;
    - go to IDLE;
    - next cycle wb_valid = 1, fault = 1, fault_code = 10, wb_reg_write = 0.
- **Stall rule:** stall = (IDLE & in_valid & aligned memory op) | (WAIT_ACK & ~dmem_ack & ~timeout).
- **Held inputs:** inputs are ignored outside IDLE. The upstream's held copy is never recaptured.
- **Flush:**
  - In IDLE, flush suppresses capture: no wb_valid.
  - In WAIT_ACK, flush moves the FSM to DRAIN and deasserts stall.
  - DRAIN keeps dmem_req = 1 until ack or timeout, then returns to IDLE.
  - DRAIN produces no wb_valid and no fault. stall = 1 while in DRAIN if in_valid carries a memory op.
- **Reset (rst_n = 0, at any time, including mid-transaction):**
  - state goes to IDLE;
  - all outputs go to 0: stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, fault, fault_code;
  - the timeout counter clears.

## Timing
- **Non-memory op latency:** 1 cycle from the in_valid edge to wb_valid.
- **Memory op latency:** N + 2 cycles for ack arriving N cycles after req first asserts (N ≥ 0).
  - dmem_req asserts the cycle after capture.
  - Ack in the first req cycle gives wb_valid 2 cycles after capture.
- **Throughput:** back-to-back non-memory ops at 1 per cycle. A memory op blocks the next instruction until its ack cycle.
- All outputs except stall are registered. stall is combinational from state, inputs, and ack.
- **Timeout:** fires on the TIMEOUT-th WAIT_ACK cycle without ack.
- **Ack on the same cycle as the timeout threshold:** ack wins; no fault.

## Structure
- The shared package holds the state enum (IDLE, WAIT_ACK, DRAIN) and the fault_code constants FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT.
- The width comes from the existing `` `WORD `` define.
- One sub-module: `mem_timeout_counter`, with clear, enable, and terminal count at TIMEOUT.

## Test plan
- **ALU pass-through:** in_alu_result = 25, reg_write = 1, no memory op → next cycle wb_valid = 1, wb_alu_result = 25, stall never high.
- **Load:** LDUR at address 0x100; ack 3 cycles after req with rdata = 0xDEAD → stall high 4 cycles, wb_read_data = 0xDEAD, wb_valid 5 cycles after capture.
- **Store:** STUR at address 0x08, data −5; ack in the first req cycle → dmem_we = 1, dmem_wdata = 0xFFFF_FFFF_FFFF_FFFB, wb_reg_write = 0.
- **Misaligned:** LDUR at address 0x104 → dmem_req never asserts; next cycle fault = 1, fault_code = 01.
- **Timeout:** TIMEOUT = 4, no ack → req drops after 4 cycles; wb_valid with fault_code = 10, wb_reg_write = 0.
- **Flush and reset mid-transaction:**
  - Flush in WAIT_ACK → stall drops that cycle; after ack, no wb_valid.
  - rst_n low in WAIT_ACK → dmem_req = 0 immediately and the FSM returns to IDLE.
